// File: rtl/dec_counter_pkg.sv
// Shared definitions for the loadable down-counter: state encoding and default width.
package dec_counter_pkg;

    localparam int DATAWIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : dec_counter_pkg

// File: rtl/dec_counter.sv
// Loadable down-counter with valid/ready start handshake, pause, abort and a
// one-cycle completion pulse. All outputs decode from registered state.
module dec_counter
    import dec_counter_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEFAULT
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [DATAWIDTH-1:0] load_val,
    input  logic                 en,
    input  logic                 abort,
    output logic [DATAWIDTH-1:0] q,
    output logic                 busy,
    output logic                 done
);

    localparam logic [DATAWIDTH-1:0] CNT_ZERO = {DATAWIDTH{1'b0}};
    localparam logic [DATAWIDTH-1:0] CNT_ONE  = {{(DATAWIDTH-1){1'b0}}, 1'b1};

    state_t                state_q;
    state_t                state_d;
    logic [DATAWIDTH-1:0]  cnt_q;
    logic [DATAWIDTH-1:0]  cnt_d;
    logic                  cnt_last_s;

    // A count of one (or a defensive zero) finishes on this edge instead of wrapping.
    assign cnt_last_s = (cnt_q <= CNT_ONE);

    // Next-state and next-count selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    cnt_d   = load_val;
                    state_d = (load_val == CNT_ZERO) ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (en) begin
                    if (cnt_last_s) begin
                        cnt_d   = CNT_ZERO;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                cnt_d   = CNT_ZERO;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = IDLE;
            end
        endcase
    end

    // State and count registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q          = cnt_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign load_ready = (state_q == IDLE);

endmodule : dec_counter

// File: tb/tb_dec_counter.sv
// Self-checking bench for dec_counter: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_dec_counter;

    logic        Clk;
    logic        Rst;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_val;
    logic        en;
    logic        abort;
    logic [31:0] q;
    logic        busy;
    logic        done;

    logic        c4_load_valid;
    logic        c4_load_ready;
    logic [3:0]  c4_load_val;
    logic        c4_en;
    logic        c4_abort;
    logic [3:0]  c4_q;
    logic        c4_busy;
    logic        c4_done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dec_counter #(.DATAWIDTH(32)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_val   (load_val),
        .en         (en),
        .abort      (abort),
        .q          (q),
        .busy       (busy),
        .done       (done)
    );

    dec_counter #(.DATAWIDTH(4)) dut4 (
        .Clk        (Clk),
        .Rst        (Rst),
        .load_valid (c4_load_valid),
        .load_ready (c4_load_ready),
        .load_val   (c4_load_val),
        .en         (c4_en),
        .abort      (c4_abort),
        .q          (c4_q),
        .busy       (c4_busy),
        .done       (c4_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: phase 0 = waiting for a start value, 1 = counting, 2 = finished.
    int          m_phase = 0;
    logic [31:0] m_left  = 32'd0;

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_phase = 0;
            m_left  = 32'd0;
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (load_valid) begin
                m_left  = load_val;
                m_phase = (load_val == 32'd0) ? 2 : 1;
            end
        end else if (abort) begin
            m_phase = 0;
        end else if (en) begin
            m_left = m_left - 32'd1;
            if (m_left == 32'd0) m_phase = 2;
        end
    end

    // Per-cycle comparison of the wide instance against the model.
    always @(negedge Clk) begin
        if (Rst === 1'b1) begin
            check("model_q",     q,          m_left);
            check("model_busy",  {31'd0, busy},       {31'd0, (m_phase != 0)});
            check("model_done",  {31'd0, done},       {31'd0, (m_phase == 2)});
            check("model_ready", {31'd0, load_ready}, {31'd0, (m_phase == 0)});
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin : stim
        logic [31:0] exp5 [6];
        logic [31:0] exp31 [6];
        logic        en31 [6];
        int          done_seen;

        exp5  = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        exp31 = '{32'd3, 32'd3, 32'd3, 32'd2, 32'd1, 32'd0};
        en31  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        Rst = 1'b0; load_valid = 1'b0; load_val = 32'd0; en = 1'b0; abort = 1'b0;
        c4_load_valid = 1'b0; c4_load_val = 4'd0; c4_en = 1'b0; c4_abort = 1'b0;
        #3;
        check("rst_q",     q, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_ready", {31'd0, load_ready}, 32'd1);
        #9 Rst = 1'b1;
        tick();

        // Load 5, en held high.
        load_valid = 1'b1; load_val = 32'd5; en = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("load5_q", q, exp5[i]);
            check("load5_done", {31'd0, done}, (i == 5) ? 32'd1 : 32'd0);
            if (i < 5) tick();
        end
        tick();
        check("load5_ready_after", {31'd0, load_ready}, 32'd1);
        check("load5_done_after", {31'd0, done}, 32'd0);

        // Load 0: straight to the finished cycle.
        load_valid = 1'b1; load_val = 32'd0;
        tick();
        load_valid = 1'b0;
        check("load0_done", {31'd0, done}, 32'd1);
        check("load0_q", q, 32'd0);
        tick();
        check("load0_idle", {31'd0, load_ready}, 32'd1);
        check("load0_busy", {31'd0, busy}, 32'd0);

        // Load 4 with en pattern 1,0,0,1,1,1.
        load_valid = 1'b1; load_val = 32'd4;
        tick();
        load_valid = 1'b0;
        check("load4_q0", q, 32'd4);
        for (int i = 0; i < 6; i++) begin
            en = en31[i];
            tick();
            check("pause_q", q, exp31[i]);
            check("pause_done", {31'd0, done}, (i == 5) ? 32'd1 : 32'd0);
        end
        en = 1'b1;
        tick();

        // Load 10, abort at 7, then load 2.
        load_valid = 1'b1; load_val = 32'd10;
        tick();
        load_valid = 1'b0;
        tick(); tick(); tick();
        check("abort_pre_q", q, 32'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_q_held", q, 32'd7);
        check("abort_idle", {31'd0, busy}, 32'd0);
        check("abort_no_done", {31'd0, done}, 32'd0);
        load_valid = 1'b1; load_val = 32'd2;
        tick();
        load_valid = 1'b0;
        check("reload_q", q, 32'd2);
        tick(); tick();
        check("reload_done", {31'd0, done}, 32'd1);
        tick();

        // Load 3; a second offer during the count is ignored.
        load_valid = 1'b1; load_val = 32'd3;
        tick();
        load_val = 32'd9;
        tick();
        check("ignore_q2", q, 32'd2);
        tick(); tick();
        load_valid = 1'b0;
        check("ignore_done", {31'd0, done}, 32'd1);
        check("ignore_q0", q, 32'd0);
        tick();

        // Reset mid-count acts before the next edge.
        load_valid = 1'b1; load_val = 32'd6;
        tick();
        load_valid = 1'b0;
        tick();
        #2 Rst = 1'b0;
        #1;
        check("arst_q", q, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ready", {31'd0, load_ready}, 32'd1);
        #2 Rst = 1'b1;
        load_valid = 1'b1; load_val = 32'd1;
        tick();
        load_valid = 1'b0;
        check("post_rst_accept", q, 32'd1);
        tick();
        check("post_rst_done", {31'd0, done}, 32'd1);
        tick();

        // Narrow instance, maximum load.
        c4_load_valid = 1'b1; c4_load_val = 4'd15; c4_en = 1'b1;
        tick();
        c4_load_valid = 1'b0;
        check("w4_q_start", {28'd0, c4_q}, 32'd15);
        done_seen = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("w4_q", {28'd0, c4_q}, 32'(15 - i));
            if (c4_done) done_seen++;
        end
        tick();
        if (c4_done) done_seen++;
        check("w4_no_wrap", {28'd0, c4_q}, 32'd0);
        check("w4_done_once", 32'(done_seen), 32'd1);
        check("w4_ready", {31'd0, c4_load_ready}, 32'd1);

        // Randomized traffic on the wide instance.
        for (int c = 0; c < 2000; c++) begin
            load_valid = ($urandom_range(0, 2) == 0);
            load_val   = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 20));
            en         = ($urandom_range(0, 3) != 0);
            abort      = ($urandom_range(0, 19) == 0);
            tick();
        end
        load_valid = 1'b0; en = 1'b0; abort = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_dec_counter
